// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWr,
    StRdWait,
    StRdData,
    StDiscard
  } state_e;

  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned CMD_INC_BIT = 6;

  localparam logic [7:0] DEF_IDLE_BYTE = 8'h00;
  localparam logic [7:0] DEF_ERR_BYTE  = 8'hEE;

endpackage

// File: rtl/spi_reg_ctrl_cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select with edge pulses.
module cs_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs_n,
  output logic o_fall,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_last;
  logic [1:0] r_vld;
  logic       r_armed;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_last  <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_meta  <= i_cs_n;
      r_sync  <= r_meta;
      r_last  <= r_sync;
      r_vld   <= {r_vld[0], 1'b1};
      // Edges count only once cs_n has been seen high after reset, so a
      // select still held low across reset cannot look like a fresh fall.
      r_armed <= r_armed | (r_vld[1] & r_sync);
    end
  end

  assign o_fall = r_armed & r_last & ~r_sync;
  assign o_rise = r_armed & ~r_last & r_sync;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frames the SPI byte stream into register-bus reads and writes.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [7:0]  IDLE_BYTE  = DEF_IDLE_BYTE,
  parameter logic [7:0]  ERR_BYTE   = DEF_ERR_BYTE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs_n,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_byte,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [7:0]        i_reg_rdata,
  input  logic              i_reg_rvalid,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err
);

  localparam int unsigned TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  logic w_fall;
  logic w_rise;

  cs_sync u_cs_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_cs_n (i_cs_n),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d, w_addr_inc;
  logic              r_inc, w_inc_d;
  logic [7:0]        r_wdata, w_wdata_d;
  logic [7:0]        r_tx, w_tx_d;
  logic [TMR_W-1:0]  r_tmr, w_tmr_d;
  logic              r_we, w_we_d;
  logic              r_re, w_re_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_err, w_err_d;

  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_comb begin
    w_state_d = r_state;
    // A write strobe from the previous cycle advances the address now.
    w_addr_d  = (r_we && r_inc) ? w_addr_inc : r_addr;
    w_inc_d   = r_inc;
    w_wdata_d = r_wdata;
    w_tx_d    = r_tx;
    w_tmr_d   = r_tmr;
    w_we_d    = 1'b0;
    w_re_d    = 1'b0;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_fall) w_state_d = StCmd;
      end
      StCmd: begin
        if (i_rx_valid) begin
          w_addr_d = i_rx_byte[ADDR_W-1:0];
          w_inc_d  = i_rx_byte[CMD_INC_BIT];
          w_tmr_d  = '0;
          if (i_rx_byte[CMD_RW_BIT]) begin
            w_re_d    = 1'b1;
            w_state_d = StRdWait;
          end else begin
            w_state_d = StWr;
          end
        end
      end
      StWr: begin
        if (i_rx_valid) begin
          w_we_d    = 1'b1;
          w_wdata_d = i_rx_byte;
        end
      end
      StRdWait: begin
        if (i_rx_valid) begin
          w_tx_d    = ERR_BYTE;
          w_err_d   = 1'b1;
          w_state_d = StDiscard;
        end else if (i_reg_rvalid) begin
          w_tx_d    = i_reg_rdata;
          w_state_d = StRdData;
        end else if (r_tmr == TMR_W'(RD_TIMEOUT - 1)) begin
          w_tx_d    = ERR_BYTE;
          w_err_d   = 1'b1;
          w_state_d = StRdData;
        end else begin
          w_tmr_d = r_tmr + TMR_W'(1);
        end
      end
      StRdData: begin
        if (i_rx_valid) begin
          w_addr_d  = r_inc ? w_addr_inc : r_addr;
          w_re_d    = 1'b1;
          w_tmr_d   = '0;
          w_state_d = StRdWait;
        end
      end
      StDiscard: ;
      default: w_state_d = StIdle;
    endcase

    // The byte accepted above still takes effect; the frame then closes.
    if (w_rise) begin
      w_done_d  = (r_state != StIdle);
      w_tx_d    = IDLE_BYTE;
      w_state_d = StIdle;
    end

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_inc   <= 1'b0;
      r_wdata <= '0;
      r_tx    <= IDLE_BYTE;
      r_tmr   <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_inc   <= w_inc_d;
      r_wdata <= w_wdata_d;
      r_tx    <= w_tx_d;
      r_tmr   <= w_tmr_d;
      r_we    <= w_we_d;
      r_re    <= w_re_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  assign o_tx_byte    = r_tx;
  assign o_reg_addr   = r_addr;
  assign o_reg_wdata  = r_wdata;
  assign o_reg_we     = r_we;
  assign o_reg_re     = r_re;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;
  assign o_err        = r_err;

endmodule
